// File: rtl/keccak_rc_gen.sv
// rtl/keccak_rc_gen.sv - Keccak-f[1600] round-constant generator driven by the 8-bit rc(t) LFSR.
// KECCAK_RC_UNROLL_EN: produce each constant in one GEN cycle instead of seven.
module keccak_rc_gen #(
  parameter int         ROUNDS    = 24,
  parameter logic [7:0] LFSR_INIT = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rc_ready,
  output logic        rc_valid,
  output logic [63:0] rc_out,
  output logic [6:0]  round_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  logic [1:0] state;
  logic [7:0] lfsr;
  logic       accept;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [8:0] t;
    t = {s, 1'b0};
    if (t[8]) t = t ^ 9'h071;
    return t[7:0];
  endfunction

  // Constant bit 2^j-1 carries rc(7*round+j).
  function automatic logic [5:0] bit_pos(input logic [2:0] j);
    logic [5:0] p;
    case (j)
      3'd0:    p = 6'd0;
      3'd1:    p = 6'd1;
      3'd2:    p = 6'd3;
      3'd3:    p = 6'd7;
      3'd4:    p = 6'd15;
      3'd5:    p = 6'd31;
      3'd6:    p = 6'd63;
      default: p = 6'd0;
    endcase
    return p;
  endfunction

  assign accept = rc_valid & rc_ready;

`ifdef KECCAK_RC_UNROLL_EN
  logic [63:0] gen_rc;
  logic [7:0]  gen_lfsr;

  always_comb begin
    gen_rc   = '0;
    gen_lfsr = lfsr;
    for (int k = 0; k < 7; k++) begin
      gen_rc[bit_pos(3'(k))] = gen_lfsr[0];
      gen_lfsr               = lfsr_step(gen_lfsr);
    end
  end
`else
  logic [2:0] j;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_INIT;
      rc_out    <= '0;
      round_out <= '0;
      rc_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifndef KECCAK_RC_UNROLL_EN
      j         <= 3'd0;
`endif
    end else begin
      done <= 1'b0;
      // start restarts from round 0 in every state and outranks an accept.
      if (start) begin
        state     <= GEN;
        lfsr      <= LFSR_INIT;
        rc_out    <= '0;
        round_out <= '0;
        rc_valid  <= 1'b0;
        busy      <= 1'b1;
`ifndef KECCAK_RC_UNROLL_EN
        j         <= 3'd0;
`endif
      end else begin
        case (state)
          GEN: begin
`ifdef KECCAK_RC_UNROLL_EN
            rc_out   <= gen_rc;
            lfsr     <= gen_lfsr;
            rc_valid <= 1'b1;
            state    <= HOLD;
`else
            rc_out[bit_pos(j)] <= lfsr[0];
            lfsr               <= lfsr_step(lfsr);
            if (j == 3'd6) begin
              j        <= 3'd0;
              rc_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              j <= j + 3'd1;
            end
`endif
          end
          HOLD: begin
            if (accept) begin
              rc_valid <= 1'b0;
              if (round_out == LAST_ROUND) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                round_out <= round_out + 7'd1;
                rc_out    <= '0;
                state     <= GEN;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keccak_rc_gen.sv
// tb/tb_keccak_rc_gen.sv - self-checking bench for keccak_rc_gen against an rc(t) reference model.
module tb_keccak_rc_gen;

`ifdef KECCAK_RC_UNROLL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, rc_ready;
  logic        rc_valid, busy, done;
  logic [63:0] rc_out;
  logic [6:0]  round_out;

  logic        start12, ready12;
  logic        valid12, busy12, done12;
  logic [63:0] rc12;
  logic [6:0]  round12;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keccak_rc_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rc_ready(rc_ready),
    .rc_valid(rc_valid), .rc_out(rc_out), .round_out(round_out),
    .busy(busy), .done(done)
  );

  keccak_rc_gen #(.ROUNDS(12)) u12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .rc_ready(ready12),
    .rc_valid(valid12), .rc_out(rc12), .round_out(round12),
    .busy(busy12), .done(done12)
  );

  // rc(t) as a bit-string LFSR: shift in a zero, fold R[8] into R[0,4,5,6], truncate.
  function automatic logic rc_bit(input int t);
    logic [8:0] r;
    int n;
    n = t % 255;
    r = 9'h001;
    for (int i = 1; i <= n; i++) begin
      r = {r[7:0], 1'b0};
      r[0] ^= r[8];
      r[4] ^= r[8];
      r[5] ^= r[8];
      r[6] ^= r[8];
      r[8] = 1'b0;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] rc_const(input int rnd);
    logic [63:0] c;
    c = '0;
    for (int j = 0; j < 7; j++) c[(1 << j) - 1] = rc_bit(7 * rnd + j);
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; rc_ready = 1'b0; start12 = 1'b0; ready12 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!rc_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (rc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_timeout: rc_valid=%b after %0d cycles, required 1", rc_valid, cyc);
    end
  endtask

  task automatic take(input int r);
    int cyc;
    wait_valid(cyc);
    n_cmp++;
    if (round_out !== 7'(r) || rc_out !== rc_const(r)) begin
      n_fail++;
      $display("FAIL take_round%0d: got round %0d rc %h, required round %0d rc %h", r, round_out, rc_out, r, rc_const(r));
    end
    rc_ready = 1'b1;
    @(negedge clk);
    rc_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (rc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got valid %b busy %b done %b, required 0 0 0", rc_valid, busy, done);
    end
    n_cmp++;
    if (rc_out !== 64'h0 || round_out !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_data: got rc %h round %0d, required 0 0", rc_out, round_out);
    end
    n_cmp++;
    if (valid12 !== 1'b0 || busy12 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_r12: got valid %b busy %b, required 0 0", valid12, busy12);
    end
  endtask

  task automatic test_full_sequence();
    int cyc, dones, stray;
    logic [63:0] lit;
    logic has_lit;
    dones = 0;
    stray = 0;
    rc_ready = 1'b1;
    pulse_start();
    for (int r = 0; r < 24; r++) begin
      wait_valid(cyc);
      n_cmp++;
      if (cyc !== LAT) begin
        n_fail++;
        $display("FAIL latency_round%0d: got %0d cycles, required %0d", r, cyc, LAT);
      end
      n_cmp++;
      if (round_out !== 7'(r) || rc_out !== rc_const(r)) begin
        n_fail++;
        $display("FAIL seq_round%0d: got round %0d rc %h, required round %0d rc %h", r, round_out, rc_out, r, rc_const(r));
      end
      has_lit = 1'b1;
      case (r)
        0:       lit = 64'h0000000000000001;
        1:       lit = 64'h0000000000008082;
        2:       lit = 64'h800000000000808A;
        23:      lit = 64'h8000000080008008;
        default: begin lit = '0; has_lit = 1'b0; end
      endcase
      if (has_lit) begin
        n_cmp++;
        if (rc_out !== lit) begin
          n_fail++;
          $display("FAIL fips_round%0d: got %h, required %h", r, rc_out, lit);
        end
      end
      @(negedge clk);
      if (done) dones++;
      if (r == 23) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          n_fail++;
          $display("FAIL seq_end: got busy %b done %b, required 0 1", busy, done);
        end
      end
    end
    rc_ready = 1'b0;
    n_cmp++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d pulses, required 1", dones);
    end
    repeat (10) begin
      @(negedge clk);
      if (done || rc_valid || busy) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL no_wrap: got %0d active cycles after done, required 0", stray);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    rc_ready = 1'b0;
    pulse_start();
    for (int r = 0; r < 3; r++) take(r);
    wait_valid(cyc);
    repeat (5) begin
      n_cmp++;
      if (rc_out !== 64'h8000000080008000 || round_out !== 7'd3 || rc_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_round3: got rc %h round %0d valid %b, required 8000000080008000 3 1", rc_out, round_out, rc_valid);
      end
      @(negedge clk);
    end
    take(3);
    wait_valid(cyc);
    n_cmp++;
    if (rc_out !== 64'h000000000000808B || round_out !== 7'd4) begin
      n_fail++;
      $display("FAIL after_hold: got rc %h round %0d, required 000000000000808b 4", rc_out, round_out);
    end
  endtask

  task automatic test_restart();
    int cyc;
    pulse_start();
    for (int r = 0; r < 10; r++) take(r);
    wait_valid(cyc);
    n_cmp++;
    if (round_out !== 7'd10) begin
      n_fail++;
      $display("FAIL pre_restart: got round %0d, required 10", round_out);
    end
    start = 1'b1;
    rc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rc_ready = 1'b0;
    n_cmp++;
    if (rc_valid !== 1'b0 || done !== 1'b0 || round_out !== 7'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_edge: got valid %b done %b round %0d busy %b, required 0 0 0 1", rc_valid, done, round_out, busy);
    end
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== LAT || round_out !== 7'd0 || rc_out !== 64'h1) begin
      n_fail++;
      $display("FAIL restart_first: got lat %0d round %0d rc %h, required %0d 0 1", cyc, round_out, rc_out, LAT);
    end
  endtask

  task automatic test_reset_mid_gen();
    int cyc;
    pulse_start();
    for (int r = 0; r < 5; r++) take(r);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rc_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rc_out !== 64'h0 || round_out !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_mid_gen: got valid %b busy %b done %b rc %h round %0d, required all 0", rc_valid, busy, done, rc_out, round_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_valid(cyc);
    n_cmp++;
    if (round_out !== 7'd0 || rc_out !== 64'h1) begin
      n_fail++;
      $display("FAIL after_reset_start: got round %0d rc %h, required 0 1", round_out, rc_out);
    end
  endtask

  task automatic test_rounds12();
    int cyc, stray;
    stray = 0;
    ready12 = 1'b1;
    start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    for (int r = 0; r < 12; r++) begin
      cyc = 0;
      while (!valid12 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if (valid12 !== 1'b1 || round12 !== 7'(r) || rc12 !== rc_const(r)) begin
        n_fail++;
        $display("FAIL r12_round%0d: got valid %b round %0d rc %h, required 1 %0d %h", r, valid12, round12, rc12, r, rc_const(r));
      end
      if (r == 11) begin
        n_cmp++;
        if (rc12 !== 64'h000000008000000A) begin
          n_fail++;
          $display("FAIL r12_last: got %h, required 000000008000000a", rc12);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (done12 !== (r == 11)) begin
        n_fail++;
        $display("FAIL r12_done%0d: got %b, required %b", r, done12, (r == 11));
      end
    end
    repeat (30) begin
      @(negedge clk);
      if (valid12 || busy12 || done12) stray++;
    end
    ready12 = 1'b0;
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL r12_no_wrap: got %0d active cycles, required 0", stray);
    end
  endtask

  task automatic test_reset_start_same();
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || rc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start_edge: got busy %b valid %b, required 0 0", busy, rc_valid);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start_idle: got busy %b valid %b, required 0 0", busy, rc_valid);
    end
  endtask

  task automatic test_random();
    logic active, exp_done;
    int exp_round;
    do_reset();
    active = 1'b0;
    exp_done = 1'b0;
    exp_round = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== exp_done || busy !== active) begin
        n_fail++;
        $display("FAIL rand_flags@%0d: got done %b busy %b, required %b %b", c, done, busy, exp_done, active);
      end
      if (rc_valid) begin
        n_cmp++;
        if (!active || round_out !== 7'(exp_round) || rc_out !== rc_const(exp_round)) begin
          n_fail++;
          $display("FAIL rand_data@%0d: got round %0d rc %h, required active round %0d rc %h", c, round_out, rc_out, exp_round, rc_const(exp_round));
        end
      end
      exp_done = 1'b0;
      start = ($urandom_range(0, 59) == 0) || (!active && $urandom_range(0, 3) == 0);
      rc_ready = ($urandom_range(0, 2) != 0);
      if (start) begin
        active = 1'b1;
        exp_round = 0;
      end else if (rc_valid && rc_ready) begin
        if (exp_round == 23) begin
          active = 1'b0;
          exp_done = 1'b1;
        end else begin
          exp_round++;
        end
      end
    end
    start = 1'b0;
    rc_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rc_ready = 1'b0; start12 = 1'b0; ready12 = 1'b0;
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_restart();
    test_reset_mid_gen();
    test_rounds12();
    test_reset_start_same();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keccak_rc_gen.md
Name: keccak_rc_gen

Overview:
- Sequential Keccak-f[1600] round-constant generator built on the standard 8-bit rc(t) LFSR.
- Produces RC[0..ROUNDS-1] in order, one constant per valid/ready transfer.
- Feeds the iota stage of the round datapath; replaces the table lookup where area matters.
- Also drives the round index, so the consumer keeps no round counter of its own.

Parameters:
- ROUNDS, 24, number of constants produced per start (legal 1..24).
- LFSR_INIT, 8'h01, LFSR value at start, equal to rc state at t=0.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  one-cycle pulse: begin a new sequence at round 0; honoured in any state.
- rc_ready  in  1  consumer accepts rc_out this cycle.
- rc_valid  out  1  rc_out/round_out hold a complete constant.
- rc_out  out  64  round constant for round_out.
- round_out  out  7  round index of rc_out (0..ROUNDS-1).
- busy  out  1  high from accepted start until the last constant is accepted.
- done  out  1  one-cycle pulse when constant ROUNDS-1 is accepted.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, lfsr=LFSR_INIT, rc_out=0, round_out=0, bit counter j=0, rc_valid=0, busy=0, done=0. Reset wins over start in the same cycle.
- LFSR step: t=lfsr<<1 (9 bits); if t[8], t^=9'h071; lfsr=t[7:0]. The emitted bit is lfsr[0] before the step.
- Round constant layout: RC bit (2^j-1) = rc(7*round+j), j=0..6. All other RC bits are 0.
- IDLE: start -> clear rc_out, lfsr=LFSR_INIT, round_out=0, j=0, busy=1, go to GEN.
- GEN: each cycle, rc_out[2^j-1] <= lfsr[0], step the LFSR, j++.
  - After j=6 is written: j=0, rc_valid=1, go to HOLD.
  - Latency: 7 cycles from start (or from the previous accept) to rc_valid.
- HOLD: rc_out, round_out and lfsr are frozen while rc_ready=0; rc_valid stays high.
- Accept = rc_valid & rc_ready. On accept:
  - If round_out==ROUNDS-1: rc_valid=0, busy=0, done=1 for one cycle, go to IDLE. rc_out keeps its last value.
  - Else: round_out++, rc_out cleared, rc_valid=0, go to GEN. The LFSR continues without reloading.
- start in GEN or HOLD: abort the current sequence and restart as from IDLE (rc_valid drops the next cycle, round_out=0). start takes priority over a same-cycle accept, and done does not pulse.
- No wrap-around past ROUNDS-1; a new start is required for the next permutation.
- rc_ready while rc_valid=0 is ignored.

Optional Feature:
- Macro: KECCAK_RC_UNROLL_EN.
- Defined: GEN computes all seven bits and seven LFSR steps combinationally in one cycle. Latency from start or accept to rc_valid is 1 cycle; the j counter is removed.
- Not defined: serial 7-cycle GEN as above.
- Handshake, reset values, outputs and constant values are identical in both builds.

Test Plan:
- Reset, pulse start, rc_ready=1 held: 24 constants in order, checked against FIPS-202, e.g.:
  - round 0 = 64'h0000000000000001
  - round 1 = 64'h0000000000008082
  - round 2 = 64'h800000000000808A
  - round 23 = 64'h8000000080008008
  - done pulses once, busy falls with it, and each rc_valid rises 7 cycles after the previous accept (1 with KECCAK_RC_UNROLL_EN).
- Backpressure: hold rc_ready=0 for 5 cycles at round 3 -> rc_out stays 64'h8000000080008000 and round_out stays 3; round 4 = 64'h000000000000808B follows the accept.
- Restart mid-sequence: pulse start while round_out=10 is valid -> next valid constant is round_out=0, rc_out=64'h1.
- Reset mid-GEN at round 5: all outputs return to reset values; a later start yields round 0 = 64'h1.
- ROUNDS=12 build: the last constant is round 11 = 64'h000000008000000A, done pulses, and nothing is produced without a new start.
- Reset and start asserted in the same cycle: block stays IDLE with busy=0.
